// File: rtl/rv_pkg.sv
// Shared register-file types and widths for the writeback path.
package rv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} wb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order sync FIFO: two write ports (port 0 lands ahead of port 1), one read port.
module wb_fifo #(
  parameter int W     = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr0_en,
  input  logic [AW-1:0]             wr0_rd,
  input  logic [W-1:0]              wr0_wd,
  input  logic                      wr1_en,
  input  logic [AW-1:0]             wr1_rd,
  input  logic [W-1:0]              wr1_wd,
  input  logic                      rd_en,
  output logic [AW-1:0]             head_rd,
  output logic [W-1:0]              head_wd,
  output logic [CW-1:0]             count,
  output logic [DEPTH-1:0]          slot_vld,
  output logic [DEPTH-1:0][AW-1:0]  slot_rd
);
  logic [DEPTH-1:0][AW-1:0] mem_rd_q, mem_rd_d;
  logic [DEPTH-1:0][W-1:0]  mem_wd_q, mem_wd_d;
  logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic [PW-1:0]            off;

  always_comb begin
    mem_rd_d = mem_rd_q;
    mem_wd_d = mem_wd_q;
    wptr_d   = wptr_q;
    if (wr0_en) begin
      mem_rd_d[wptr_d] = wr0_rd;
      mem_wd_d[wptr_d] = wr0_wd;
      wptr_d           = wptr_d + PW'(1);
    end
    if (wr1_en) begin
      mem_rd_d[wptr_d] = wr1_rd;
      mem_wd_d[wptr_d] = wr1_wd;
      wptr_d           = wptr_d + PW'(1);
    end
    rptr_d  = rd_en ? rptr_q + PW'(1) : rptr_q;
    count_d = count_q + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; only occupancy decides what is live.
  always_ff @(posedge clk) begin
    mem_rd_q <= mem_rd_d;
    mem_wd_q <= mem_wd_d;
  end

  always_comb begin
    off      = '0;
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = PW'(i) - rptr_q;
      slot_vld[i] = CW'(off) < count_q;
    end
  end

  assign head_rd = mem_rd_q[rptr_q];
  assign head_wd = mem_wd_q[rptr_q];
  assign count   = count_q;
  assign slot_rd = mem_rd_q;
endmodule

// File: rtl/rf_wb_ctrl.sv
// Writeback controller: arbitrates ALU/load results into a FIFO, retires one write
// per cycle to the register file, publishes pending writes, and zero-fills x1..x31.
module rf_wb_ctrl #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          alu_valid,
  input  logic [rv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]               alu_wd,
  output logic                          alu_ready,
  input  logic                          ld_valid,
  input  logic [rv_pkg::REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]               ld_wd,
  output logic                          ld_ready,
  input  logic                          clr_start,
  output logic                          clr_busy,
  output logic                          rf_we,
  output logic [rv_pkg::REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]               rf_wd,
  output logic [rv_pkg::NUM_REGS-1:0]   pend
);
  import rv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  wb_state_t                          state_q, state_d;
  logic [REG_ADDR_W-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]                      count, free;
  logic                               empty, pop, alu_push, ld_push;
  logic [REG_ADDR_W-1:0]              head_rd;
  logic [XLEN-1:0]                    head_wd;
  logic [DEPTH-1:0]                   slot_vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0]   slot_rd;

  assign empty = (count == '0);
  assign free  = CW'(DEPTH) - count;

  // Readies look only at the registered count so a full FIFO never accepts, even while popping.
  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (state_q == IDLE) begin
      if (free >= CW'(2)) begin
        alu_ready = 1'b1;
        ld_ready  = 1'b1;
      end else if (free == CW'(1)) begin
        ld_ready  = 1'b1;
        alu_ready = !ld_valid;
      end
    end
  end

  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign ld_push  = ld_valid && ld_ready && (ld_rd != '0);

  wb_fifo #(.W(XLEN), .AW(REG_ADDR_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr0_en   (alu_push),
    .wr0_rd   (alu_rd),
    .wr0_wd   (alu_wd),
    .wr1_en   (ld_push),
    .wr1_rd   (ld_rd),
    .wr1_wd   (ld_wd),
    .rd_en    (pop),
    .head_rd  (head_rd),
    .head_wd  (head_wd),
    .count    (count),
    .slot_vld (slot_vld),
    .slot_rd  (slot_rd)
  );

  // DRAIN leaves as its last entry retires, so CLEAR follows the final pop directly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (clr_start) state_d = DRAIN;
      DRAIN: if (count <= CW'(1)) begin
        state_d = CLEAR;
        cnt_d   = REG_ADDR_W'(1);
      end
      CLEAR: begin
        cnt_d = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = REG_ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= REG_ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rf_we = !empty;
    rf_rd = head_rd;
    rf_wd = head_wd;
    if (state_q == CLEAR) begin
      rf_we = 1'b1;
      rf_rd = cnt_q;
      rf_wd = '0;
    end
  end

  assign pop      = rf_we && (state_q != CLEAR);
  assign clr_busy = (state_q != IDLE);

  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_vld[i]) pend[slot_rd[i]] = 1'b1;
    end
    pend[0] = 1'b0;
  end
endmodule
